// File: rtl/multi_laser_draw_pkg.sv
// Shared types and constants for the multi-slot laser engine.
// Latency: n/a (types, constants and a spawn helper only).
// Backpressure: n/a.
package multi_laser_draw_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ERASE,
        S_MOVE,
        S_CHECK,
        S_KILL,
        S_DRAW,
        S_DONE
    } laser_state_t;

    typedef struct packed {
        logic           alive;
        logic           fresh;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } laser_slot_t;

    // New lasers start just above the player sprite; unsigned wrap if the player sits too high.
    function automatic logic [Y_W-1:0] spawn_y(input logic [Y_W-1:0] player_y,
                                               input int player_height,
                                               input int laser_length);
        return player_y - Y_W'(player_height / 2 + laser_length);
    endfunction

endpackage

// File: rtl/multi_laser_draw_if.sv
// Bundles pixel, hit-query, kill and status signals of the multi-slot laser engine.
// Latency: n/a (wiring only); master = engine side, slave = environment side.
// Backpressure: pixels use pix_valid/pix_ready, hit queries use hit_req/hit_valid.
interface multi_laser_draw_if #(parameter int NUM_LASERS = 4);
    import multi_laser_draw_pkg::*;

    logic                  frame_tick;
    logic                  fire;
    logic [X_W-1:0]        player_x;
    logic [Y_W-1:0]        player_y;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [X_W-1:0]        pix_x;
    logic [Y_W-1:0]        pix_y;
    logic [3:0]            pix_color;
    logic                  hit_req;
    logic [X_W-1:0]        hit_x;
    logic [Y_W-1:0]        hit_y;
    logic                  hit_valid;
    logic                  hit;
    logic [4:0]            hit_alien;
    logic                  kill_wren;
    logic [4:0]            kill_alien;
    logic                  fire_dropped;
    logic                  busy;
    logic                  pass_done;
    logic [NUM_LASERS-1:0] live_mask;
`ifdef MULTI_LASER_STATS_EN
    logic [15:0]           shots_fired;
    logic [15:0]           kills;
`endif

    modport master (
        input  frame_tick, fire, player_x, player_y, pix_ready, hit_valid, hit, hit_alien,
        output pix_valid, pix_x, pix_y, pix_color, hit_req, hit_x, hit_y,
        output kill_wren, kill_alien, fire_dropped, busy, pass_done, live_mask
`ifdef MULTI_LASER_STATS_EN
        , output shots_fired, kills
`endif
    );

    modport slave (
        output frame_tick, fire, player_x, player_y, pix_ready, hit_valid, hit, hit_alien,
        input  pix_valid, pix_x, pix_y, pix_color, hit_req, hit_x, hit_y,
        input  kill_wren, kill_alien, fire_dropped, busy, pass_done, live_mask
`ifdef MULTI_LASER_STATS_EN
        , input shots_fired, kills
`endif
    );

endinterface

// File: rtl/multi_laser_draw_rect_raster.sv
// Row-major rectangle rasteriser emitting one pixel per accepted handshake.
// Latency: first pixel valid the cycle after start; last pulses on the final accepted pixel.
// Backpressure: holds pix_x/pix_y/pix_color while pix_valid && !pix_ready.
module multi_laser_draw_rect_raster
    import multi_laser_draw_pkg::*;
(
    input  logic           clock,
    input  logic           global_reset_n,
    input  logic           start,
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y0,
    input  logic [Y_W-1:0] y1,
    input  logic [3:0]     color,
    input  logic           pix_ready,
    output logic           pix_valid,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic [3:0]     pix_color,
    output logic           last
);

    logic           active_q, active_d;
    logic [X_W-1:0] cur_x_q, cur_x_d, x0_q, x0_d, x1_q, x1_d;
    logic [Y_W-1:0] cur_y_q, cur_y_d, y1_q, y1_d;
    logic [3:0]     color_q, color_d;

    always_comb begin
        active_d = active_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        x0_d     = x0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        color_d  = color_q;
        last     = 1'b0;
        if (start) begin
            active_d = 1'b1;
            cur_x_d  = x0;
            cur_y_d  = y0;
            x0_d     = x0;
            x1_d     = x1;
            y1_d     = y1;
            color_d  = color;
        end else if (active_q && pix_ready) begin
            if (cur_x_q == x1_q) begin
                if (cur_y_q == y1_q) begin
                    active_d = 1'b0;
                    last     = 1'b1;
                end else begin
                    cur_x_d = x0_q;
                    cur_y_d = cur_y_q + Y_W'(1);
                end
            end else begin
                cur_x_d = cur_x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            active_q <= 1'b0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            x0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            color_q  <= '0;
        end else begin
            active_q <= active_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            x0_q     <= x0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            color_q  <= color_d;
        end
    end

    assign pix_valid = active_q;
    assign pix_x     = active_q ? cur_x_q : '0;
    assign pix_y     = active_q ? cur_y_q : '0;
    assign pix_color = active_q ? color_q : '0;

endmodule

// File: rtl/multi_laser_draw.sv
// Multi-slot laser engine: per frame, erase/advance/hit-test/redraw each live slot in index order.
// Latency: pass starts the cycle after frame_tick; one pixel per cycle with pix_ready high.
// Backpressure: pixel stream stalls on !pix_ready, CHECK waits on hit_valid. MULTI_LASER_STATS_EN adds counters.
module multi_laser_draw
    import multi_laser_draw_pkg::*;
#(
    parameter int NUM_LASERS           = 4,
    parameter int LASER_WIDTH          = 5,
    parameter int LASER_LENGTH         = 10,
    parameter int LASER_SPEED          = 5,
    parameter int PLAYER_HEIGHT        = 32,
    parameter int BACKGROUND_COLOR_NUM = 0,
    parameter int LASER_COLOR_NUM      = 2
) (
    input logic               clock,
    input logic               global_reset_n,
    multi_laser_draw_if.master bus
);

    localparam int IDX_W  = (NUM_LASERS > 1) ? $clog2(NUM_LASERS) : 1;
    localparam int HALF_W = LASER_WIDTH / 2;

    laser_state_t          state_q, state_d;
    laser_slot_t           slot_q [NUM_LASERS];
    laser_slot_t           slot_d [NUM_LASERS];
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W:0]        scan_from_q, scan_from_d, next_from;
    logic                  fire_pending_q, fire_pending_d;
    logic [4:0]            alien_q, alien_d;
    logic [NUM_LASERS-1:0] live_mask_q, live_mask_d;

    logic             free_found, scan_found, alloc, fire_drop;
    logic [IDX_W-1:0] free_idx, scan_idx;
    logic [X_W-1:0]   rsel_x, rx0, rx1;
    logic [X_W:0]     rx_sum;
    logic [Y_W-1:0]   rsel_y, ry1;
    logic             raster_start, raster_last;
    logic [3:0]       raster_color;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = NUM_LASERS - 1; i >= 0; i--) begin
            if (!slot_q[i].alive) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (slot_q[i].alive && ((IDX_W+1)'(i) >= scan_from_q)) begin
                scan_found = 1'b1;
                scan_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_LASERS; i++) live_mask_d[i] = slot_q[i].alive;
    end

    // During SCAN the rectangle belongs to the slot being selected, otherwise to the current slot.
    always_comb begin
        rsel_x = (state_q == S_SCAN) ? slot_q[scan_idx].x : slot_q[idx_q].x;
        rsel_y = (state_q == S_SCAN) ? slot_q[scan_idx].y : slot_q[idx_q].y;
        rx0    = (rsel_x >= X_W'(HALF_W)) ? rsel_x - X_W'(HALF_W) : '0;
        rx_sum = {1'b0, rsel_x} + (X_W+1)'(HALF_W);
        rx1    = (rx_sum > (X_W+1)'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : rx_sum[X_W-1:0];
        ry1    = rsel_y + Y_W'(LASER_LENGTH - 1);
    end

    assign next_from = {1'b0, idx_q} + (IDX_W+1)'(1);
    assign alloc     = (state_q == S_IDLE) && fire_pending_q && free_found;
    assign fire_drop = (state_q == S_IDLE) && fire_pending_q && !free_found;

    always_comb begin
        state_d        = state_q;
        slot_d         = slot_q;
        idx_d          = idx_q;
        scan_from_d    = scan_from_q;
        fire_pending_d = fire_pending_q | bus.fire;
        alien_d        = alien_q;
        raster_start   = 1'b0;
        raster_color   = 4'(LASER_COLOR_NUM);
        case (state_q)
            S_IDLE: begin
                if (fire_pending_q) fire_pending_d = bus.fire;
                if (alloc) begin
                    slot_d[free_idx].alive = 1'b1;
                    slot_d[free_idx].fresh = 1'b1;
                    slot_d[free_idx].x     = bus.player_x;
                    slot_d[free_idx].y     = spawn_y(bus.player_y, PLAYER_HEIGHT, LASER_LENGTH);
                end
                if (bus.frame_tick) begin
                    state_d     = S_SCAN;
                    scan_from_d = '0;
                end
            end
            S_SCAN: begin
                if (!scan_found) begin
                    state_d = S_DONE;
                end else begin
                    idx_d        = scan_idx;
                    raster_start = 1'b1;
                    if (slot_q[scan_idx].fresh) begin
                        state_d = S_DRAW;
                    end else begin
                        state_d      = S_ERASE;
                        raster_color = 4'(BACKGROUND_COLOR_NUM);
                    end
                end
            end
            S_ERASE: if (raster_last) state_d = S_MOVE;
            S_MOVE: begin
                if (slot_q[idx_q].y <= Y_W'(LASER_SPEED)) begin
                    slot_d[idx_q].alive = 1'b0;
                    scan_from_d         = next_from;
                    state_d             = S_SCAN;
                end else begin
                    slot_d[idx_q].y = slot_q[idx_q].y - Y_W'(LASER_SPEED);
                    state_d         = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bus.hit_valid) begin
                    if (bus.hit) begin
                        alien_d = bus.hit_alien;
                        state_d = S_KILL;
                    end else begin
                        raster_start = 1'b1;
                        state_d      = S_DRAW;
                    end
                end
            end
            S_KILL: begin
                slot_d[idx_q].alive = 1'b0;
                scan_from_d         = next_from;
                state_d             = S_SCAN;
            end
            S_DRAW: begin
                if (raster_last) begin
                    slot_d[idx_q].fresh = 1'b0;
                    scan_from_d         = next_from;
                    state_d             = S_SCAN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q        <= S_IDLE;
            for (int i = 0; i < NUM_LASERS; i++) slot_q[i] <= '0;
            idx_q          <= '0;
            scan_from_q    <= '0;
            fire_pending_q <= 1'b0;
            alien_q        <= '0;
            live_mask_q    <= '0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            idx_q          <= idx_d;
            scan_from_q    <= scan_from_d;
            fire_pending_q <= fire_pending_d;
            alien_q        <= alien_d;
            live_mask_q    <= live_mask_d;
        end
    end

    multi_laser_draw_rect_raster u_raster (
        .clock          (clock),
        .global_reset_n (global_reset_n),
        .start          (raster_start),
        .x0             (rx0),
        .x1             (rx1),
        .y0             (rsel_y),
        .y1             (ry1),
        .color          (raster_color),
        .pix_ready      (bus.pix_ready),
        .pix_valid      (bus.pix_valid),
        .pix_x          (bus.pix_x),
        .pix_y          (bus.pix_y),
        .pix_color      (bus.pix_color),
        .last           (raster_last)
    );

    assign bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.pass_done    = (state_q == S_DONE);
    assign bus.hit_req      = (state_q == S_CHECK);
    assign bus.hit_x        = (state_q == S_CHECK) ? slot_q[idx_q].x : '0;
    assign bus.hit_y        = (state_q == S_CHECK) ? slot_q[idx_q].y : '0;
    assign bus.kill_wren    = (state_q == S_KILL);
    assign bus.kill_alien   = (state_q == S_KILL) ? alien_q : '0;
    assign bus.fire_dropped = fire_drop;
    assign bus.live_mask    = live_mask_q;

`ifdef MULTI_LASER_STATS_EN
    logic [15:0] shots_q, shots_d, kills_q, kills_d;

    always_comb begin
        shots_d = shots_q;
        kills_d = kills_q;
        if (alloc && (shots_q != 16'hFFFF)) shots_d = shots_q + 16'd1;
        if ((state_q == S_KILL) && (kills_q != 16'hFFFF)) kills_d = kills_q + 16'd1;
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            shots_q <= '0;
            kills_q <= '0;
        end else begin
            shots_q <= shots_d;
            kills_q <= kills_d;
        end
    end

    assign bus.shots_fired = shots_q;
    assign bus.kills       = kills_q;
`endif

endmodule

// File: tb/tb_multi_laser_draw.sv
// Scoreboard bench for multi_laser_draw: a slot-level model queues expected pixels, queries and kills;
// independent monitors pop and compare whenever the DUT presents them.
module tb_multi_laser_draw;

    localparam int N     = 4;
    localparam int LEN   = 10;
    localparam int SPEED = 5;
    localparam int HALFW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_laser_draw_if #(.NUM_LASERS(N)) bus();

    multi_laser_draw #(
        .NUM_LASERS(N), .LASER_WIDTH(5), .LASER_LENGTH(LEN), .LASER_SPEED(SPEED),
        .PLAYER_HEIGHT(32), .BACKGROUND_COLOR_NUM(0), .LASER_COLOR_NUM(2)
    ) dut (
        .clock          (clk),
        .global_reset_n (rst_n),
        .bus            (bus)
    );

    typedef struct { int hit; int alien; int lat; } resp_t;
    typedef struct { int alive; int fresh; int x; int y; } mslot_t;

    int     pix_q[$];
    int     qry_q[$];
    int     kill_q[$];
    resp_t  resp_q[$];
    resp_t  force_q[$];
    mslot_t m [N];
    int     m_pending;
    int     drops_exp, drops_seen;
    int     checks, failures;
    bit     rand_ready;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic int pack_pix(int x, int y, int c);
        return (x << 13) | (y << 4) | c;
    endfunction

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < N; i++) m[i] = '{0, 0, 0, 0};
        m_pending = 0;
        drops_exp = 0;
    endfunction

    function automatic void push_rect(int x, int y, int c);
        int lo, hi;
        lo = (x - HALFW < 0) ? 0 : x - HALFW;
        hi = (x + HALFW > 639) ? 639 : x + HALFW;
        for (int r = 0; r < LEN; r++)
            for (int col = lo; col <= hi; col++)
                pix_q.push_back(pack_pix(col, y + r, c));
    endfunction

    function automatic void model_fire(int px, int py);
        for (int i = 0; i < N; i++) begin
            if (m[i].alive == 0) begin
                m[i] = '{1, 1, px, (py - 26) & 511};
                return;
            end
        end
        drops_exp++;
    endfunction

    function automatic void model_pass();
        resp_t r;
        for (int i = 0; i < N; i++) begin
            if (m[i].alive == 0) continue;
            if (m[i].fresh != 0) begin
                push_rect(m[i].x, m[i].y, 2);
                m[i].fresh = 0;
                continue;
            end
            push_rect(m[i].x, m[i].y, 0);
            if (m[i].y <= SPEED) begin
                m[i].alive = 0;
                continue;
            end
            m[i].y -= SPEED;
            qry_q.push_back((m[i].x << 9) | m[i].y);
            if (force_q.size() > 0) r = force_q.pop_front();
            else r = '{($urandom_range(3) == 0) ? 1 : 0, int'($urandom_range(31)), int'($urandom_range(1, 4))};
            resp_q.push_back(r);
            if (r.hit != 0) begin
                kill_q.push_back(r.alien);
                m[i].alive = 0;
            end else begin
                push_rect(m[i].x, m[i].y, 2);
            end
        end
    endfunction

    function automatic int model_mask();
        int v = 0;
        for (int i = 0; i < N; i++) if (m[i].alive != 0) v |= (1 << i);
        return v;
    endfunction

    // ---------------- environment drivers / monitors ----------------
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.pix_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
        end
    end

    initial begin
        int    saved;
        bit    stalled;
        stalled = 0;
        saved = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin stalled = 0; continue; end
            if (stalled)
                chk("pix_hold", {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_color}, {1'b1, saved[22:0]});
            if (bus.pix_valid && bus.pix_ready) begin
                if (pix_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pix_extra: unexpected pixel x=%0d y=%0d c=%0d", bus.pix_x, bus.pix_y, bus.pix_color);
                end else begin
                    chk("pix_data", {bus.pix_x, bus.pix_y, bus.pix_color}, pix_q.pop_front());
                end
            end
            stalled = bus.pix_valid && !bus.pix_ready;
            saved = {9'd0, bus.pix_x, bus.pix_y, bus.pix_color};
        end
    end

    initial begin
        resp_t r;
        bus.hit_valid = 1'b0;
        bus.hit = 1'b0;
        bus.hit_alien = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.hit_req) continue;
            if (qry_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL hit_extra: unexpected query x=%0d y=%0d", bus.hit_x, bus.hit_y);
                r = '{0, 0, 1};
            end else begin
                chk("hit_query", {bus.hit_x, bus.hit_y}, qry_q.pop_front());
                r = (resp_q.size() > 0) ? resp_q.pop_front() : '{0, 0, 1};
            end
            repeat (r.lat) @(posedge clk);
            #1;
            chk("hit_req_held", bus.hit_req, 1);
            bus.hit_valid = 1'b1;
            bus.hit = r.hit[0];
            bus.hit_alien = r.alien[4:0];
            @(posedge clk);
            #1;
            bus.hit_valid = 1'b0;
            bus.hit = 1'b0;
            bus.hit_alien = '0;
        end
    end

    initial begin
        bit prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin prev = 0; continue; end
            if (bus.fire_dropped) drops_seen++;
            if (bus.kill_wren) begin
                chk("kill_one_cycle", prev, 0);
                if (kill_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL kill_extra: unexpected kill alien=%0d", bus.kill_alien);
                end else begin
                    chk("kill_alien", bus.kill_alien, kill_q.pop_front());
                end
            end
            prev = bus.kill_wren;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic longint all_outputs();
        return {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_color, bus.hit_req, bus.hit_x, bus.hit_y,
                bus.kill_wren, bus.kill_alien, bus.fire_dropped, bus.busy, bus.pass_done, bus.live_mask};
    endfunction

    task automatic apply_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        bus.fire = 1'b0;
        bus.frame_tick = 1'b0;
        pix_q.delete();
        qry_q.delete();
        kill_q.delete();
        resp_q.delete();
        force_q.delete();
        model_reset();
        drops_seen = 0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
    endtask

    task automatic fire_idle(int px, int py);
        bus.player_x = 10'(px);
        bus.player_y = 9'(py);
        bus.fire = 1'b1;
        wait_cyc(1);
        bus.fire = 1'b0;
        model_fire(px, py);
        wait_cyc(3);
    endtask

    task automatic run_pass(bit disturb);
        bit had_live, found;
        had_live = (model_mask() != 0);
        model_pass();
        bus.frame_tick = 1'b1;
        wait_cyc(1);
        bus.frame_tick = 1'b0;
        if (disturb && had_live) begin
            wait_cyc(2);
            bus.fire = 1'b1;
            wait_cyc(1);
            bus.fire = 1'b0;
            m_pending = 1;
            bus.frame_tick = 1'b1;
            wait_cyc(1);
            bus.frame_tick = 1'b0;
        end
        found = 0;
        for (int c = 0; c < 20000 && !found; c++) begin
            @(negedge clk);
            if (bus.pass_done) found = 1;
        end
        chk("pass_done_seen", found, 1);
        wait_cyc(4);
        if (m_pending != 0) begin
            model_fire(int'(bus.player_x), int'(bus.player_y));
            m_pending = 0;
        end
        chk("pix_left", pix_q.size(), 0);
        chk("qry_left", qry_q.size(), 0);
        chk("kill_left", kill_q.size(), 0);
        chk("live_mask", bus.live_mask, model_mask());
        chk("busy_idle", bus.busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        checks = 0;
        failures = 0;
        rand_ready = 0;
        drops_seen = 0;
        bus.fire = 1'b0;
        bus.frame_tick = 1'b0;
        bus.player_x = '0;
        bus.player_y = '0;
        model_reset();
        #2;
        chk("reset_outputs", all_outputs(), 0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
        chk("post_reset_outputs", all_outputs(), 0);

        // Spawn, first draw, then erase/move/check/redraw.
        fire_idle(320, 440);
        run_pass(0);
        force_q.push_back('{0, 0, 2});
        run_pass(0);

        // Five fires into four slots: fifth is dropped.
        apply_reset();
        for (int i = 0; i < 5; i++) fire_idle(100 + 50 * i, 300);
        chk("live_mask_full", bus.live_mask, 4'b1111);
        chk("drops_five", drops_seen, drops_exp);
        run_pass(0);

        // Laser at y=5 retires after erase with no query.
        apply_reset();
        fire_idle(100, 31);
        run_pass(0);
        run_pass(0);
        chk("retired_mask", bus.live_mask, 0);

        // Hit with 3-cycle latency kills slot 0; slot 1 continues.
        apply_reset();
        fire_idle(200, 300);
        fire_idle(400, 300);
        run_pass(0);
        force_q.push_back('{1, 7, 3});
        force_q.push_back('{0, 0, 2});
        run_pass(0);
        chk("kill_mask", bus.live_mask, 4'b0010);

        // Screen-edge clipping.
        apply_reset();
        fire_idle(0, 200);
        fire_idle(639, 200);
        fire_idle(1, 250);
        fire_idle(638, 250);
        run_pass(0);
        run_pass(0);

        // Randomised traffic with stalls, busy-time fires and ignored ticks.
        apply_reset();
        rand_ready = 1;
        for (int it = 0; it < 40; it++) begin
            int nf;
            nf = int'($urandom_range(2));
            for (int f = 0; f < nf; f++)
                fire_idle(int'($urandom_range(639)), int'($urandom_range(26, 479)));
            run_pass($urandom_range(2) == 0);
        end
        chk("drops_random", drops_seen, drops_exp);

        // Asynchronous reset in the middle of a draw.
        apply_reset();
        fire_idle(320, 440);
        model_pass();
        bus.frame_tick = 1'b1;
        wait_cyc(1);
        bus.frame_tick = 1'b0;
        wait_cyc(12);
        chk("mid_draw_active", bus.pix_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outputs(), 0);
        pix_q.delete();
        model_reset();
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(20);
        chk("after_reset_quiet", all_outputs(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
